fwd_pipe_ctrl: RTL and testbench
================================

Name: fwd_pipe_ctrl

Overview:
- Producer side of the EX-stage forwarding interface: generates ForwardA/ForwardB for the ALU stage.
- Owns the EX/MEM and MEM/WB pipeline registers whose contents those selects point at.
- Supplies the final writeback data that EX consumes on its MEM_WB_read_data input.
- Detects load-use hazards and raises a stall to the IF/ID and ID/EX stages.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the statistics counters (used only with FWD_STATS_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- id_ex_rs  in  REG_AW  rs of the instruction in EX.
- id_ex_rt  in  REG_AW  rt of the instruction in EX.
- id_ex_write_reg  in  REG_AW  destination after the RegDst mux.
- id_ex_reg_write  in  1  EX instruction writes the register file.
- id_ex_mem_read  in  1  EX instruction is a load.
- id_ex_mem_write  in  1  EX instruction is a store.
- if_id_rs  in  REG_AW  rs of the instruction in ID.
- if_id_rt  in  REG_AW  rt of the instruction in ID.
- alu_result  in  DATA_W  ALU output from EX.
- write_data  in  DATA_W  forwarded store data from EX.
- mem_read_data  in  DATA_W  data-memory read data (MEM stage, combinational).
- flush  in  1  squash the instruction currently in EX.
- ForwardA  out  2  A-operand select.
- ForwardB  out  2  B-operand select.
- stall  out  1  load-use hazard.
- ex_mem_alu_result  out  DATA_W  EX/MEM ALU result.
- ex_mem_write_data  out  DATA_W  EX/MEM store data.
- ex_mem_write_reg  out  REG_AW  EX/MEM destination register.
- ex_mem_reg_write  out  1  EX/MEM register-write enable.
- ex_mem_mem_read  out  1  EX/MEM load flag.
- ex_mem_mem_write  out  1  EX/MEM store flag.
- mem_wb_write_data  out  DATA_W  final writeback value.
- mem_wb_write_reg  out  REG_AW  MEM/WB destination register.
- mem_wb_reg_write  out  1  MEM/WB register-write enable.
- fwd_cnt  out  CNT_W  forwarding-event counter.
- stall_cnt  out  CNT_W  stall-cycle counter.

Behaviour:

Reset
- rst=1 asynchronously clears every register and counter; all outputs read 0.
- Consequences: ForwardA=ForwardB=00, stall=0.
- Reset mid-operation discards in-flight EX/MEM and MEM/WB contents; no write is retained.

EX/MEM register (every posedge, no enable)
- Captures alu_result, write_data, id_ex_write_reg, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write.
- If flush=1: the three control bits capture 0. Data fields still capture and are don't-care.

MEM/WB register (every posedge)
- mem_wb_write_data <= ex_mem_mem_read ? mem_read_data : ex_mem_alu_result.
- mem_wb_write_reg <= ex_mem_write_reg.
- mem_wb_reg_write <= ex_mem_reg_write.
- Latency: 1 cycle EX to EX/MEM, 1 cycle EX/MEM to MEM/WB.

Forwarding (combinational from registered state plus id_ex_rs/rt)
- ForwardA = 10 if ex_mem_reg_write && ex_mem_write_reg!=0 && ex_mem_write_reg==id_ex_rs.
- Else ForwardA = 01 if mem_wb_reg_write && mem_wb_write_reg!=0 && mem_wb_write_reg==id_ex_rs.
- Else ForwardA = 00.
- ForwardB: identical rules using id_ex_rt.
- Both stages matching: EX/MEM wins (the newer value).
- Register 0 is never forwarded.
- 11 is never produced.

Load-use stall (combinational)
- stall = id_ex_mem_read && id_ex_write_reg!=0 && (id_ex_write_reg==if_id_rs || id_ex_write_reg==if_id_rt).
- This block does not gate itself on stall; the EX/MEM register keeps advancing.
- Freezing IF/ID and bubbling ID/EX are the caller's job.
- flush and stall together: stall is still reported; the flushed load does not commit.

Optional Feature:
- Macro: FWD_STATS_EN.
- Defined:
  - fwd_cnt increments by 1 on each posedge where ForwardA!=00 or ForwardB!=00. A cycle with both non-zero counts once.
  - stall_cnt increments on each posedge where stall=1.
  - Both counters saturate at all-ones; no wrap.
  - Both clear on rst.
- Undefined: no counter flops; fwd_cnt and stall_cnt are tied to 0.

Test Plan:
- Reset: assert rst mid-stream with EX/MEM holding reg_write=1, write_reg=5 -> all outputs 0 immediately (asynchronous); ForwardA=00.
- EX/MEM forward: cycle N id_ex_write_reg=3, reg_write=1, alu_result=0x0000_0010; cycle N+1 id_ex_rs=3, id_ex_rt=4 -> ForwardA=10, ForwardB=00, ex_mem_alu_result=0x10.
- Priority and MEM/WB forward: two consecutive writes to r7 (values 0xA, then 0xB), then id_ex_rt=7 -> ForwardB=10. One cycle later with no new r7 writer -> ForwardB=01, mem_wb_write_data=0xB.
- Load path and stall: EX holds a load with write_reg=8 while if_id_rt=8 -> stall=1 that cycle. Two cycles later, mem_read_data=0xDEAD_BEEF -> mem_wb_write_data=0xDEADBEEF.
- Zero register and flush:
  - Write to r0 with id_ex_rs=0 -> ForwardA=00.
  - A load to r0 with if_id_rs=0 -> stall=0.
  - flush=1 on a writer of r9 -> ex_mem_reg_write=0 and no forward to a following rs=9.
- FWD_STATS_EN: 3 forwarding cycles (one with both selects active) plus 2 stall cycles -> fwd_cnt=3, stall_cnt=2. Without the macro both read 0.

Source files
------------

// File: rtl/fwd_pipe_ctrl.sv
// EX-stage forwarding producer: owns EX/MEM and MEM/WB, generates ForwardA/ForwardB and load-use stall.
// Optional forwarding/stall statistics counters are built when FWD_STATS_EN is defined.
module fwd_pipe_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_ex_rs,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] id_ex_write_reg,
    input  logic              id_ex_reg_write,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_mem_write,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              flush,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              stall,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [DATA_W-1:0] ex_mem_write_data,
    output logic [REG_AW-1:0] ex_mem_write_reg,
    output logic              ex_mem_reg_write,
    output logic              ex_mem_mem_read,
    output logic              ex_mem_mem_write,
    output logic [DATA_W-1:0] mem_wb_write_data,
    output logic [REG_AW-1:0] mem_wb_write_reg,
    output logic              mem_wb_reg_write,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] ex_mem_alu_result_q;
    logic [DATA_W-1:0] ex_mem_write_data_q;
    logic [REG_AW-1:0] ex_mem_write_reg_q;
    logic              ex_mem_reg_write_q;
    logic              ex_mem_mem_read_q;
    logic              ex_mem_mem_write_q;

    logic              ex_mem_reg_write_d;
    logic              ex_mem_mem_read_d;
    logic              ex_mem_mem_write_d;

    logic [DATA_W-1:0] mem_wb_write_data_q;
    logic [REG_AW-1:0] mem_wb_write_reg_q;
    logic              mem_wb_reg_write_q;
    logic [DATA_W-1:0] mem_wb_write_data_d;

    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              stall_d;

    // A flushed instruction keeps its data fields but loses every side effect.
    always_comb begin
        ex_mem_reg_write_d = id_ex_reg_write;
        ex_mem_mem_read_d  = id_ex_mem_read;
        ex_mem_mem_write_d = id_ex_mem_write;
        if (flush) begin
            ex_mem_reg_write_d = 1'b0;
            ex_mem_mem_read_d  = 1'b0;
            ex_mem_mem_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_alu_result_q <= '0;
            ex_mem_write_data_q <= '0;
            ex_mem_write_reg_q  <= '0;
            ex_mem_reg_write_q  <= 1'b0;
            ex_mem_mem_read_q   <= 1'b0;
            ex_mem_mem_write_q  <= 1'b0;
        end else begin
            ex_mem_alu_result_q <= alu_result;
            ex_mem_write_data_q <= write_data;
            ex_mem_write_reg_q  <= id_ex_write_reg;
            ex_mem_reg_write_q  <= ex_mem_reg_write_d;
            ex_mem_mem_read_q   <= ex_mem_mem_read_d;
            ex_mem_mem_write_q  <= ex_mem_mem_write_d;
        end
    end

    always_comb begin
        mem_wb_write_data_d = ex_mem_alu_result_q;
        if (ex_mem_mem_read_q) begin
            mem_wb_write_data_d = mem_read_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_write_data_q <= '0;
            mem_wb_write_reg_q  <= '0;
            mem_wb_reg_write_q  <= 1'b0;
        end else begin
            mem_wb_write_data_q <= mem_wb_write_data_d;
            mem_wb_write_reg_q  <= ex_mem_write_reg_q;
            mem_wb_reg_write_q  <= ex_mem_reg_write_q;
        end
    end

    // EX/MEM is checked first so the newer value wins; r0 is never forwarded.
    always_comb begin
        forward_a = 2'b00;
        if (ex_mem_reg_write_q && (ex_mem_write_reg_q != '0) &&
            (ex_mem_write_reg_q == id_ex_rs)) begin
            forward_a = 2'b10;
        end else if (mem_wb_reg_write_q && (mem_wb_write_reg_q != '0) &&
                     (mem_wb_write_reg_q == id_ex_rs)) begin
            forward_a = 2'b01;
        end
    end

    always_comb begin
        forward_b = 2'b00;
        if (ex_mem_reg_write_q && (ex_mem_write_reg_q != '0) &&
            (ex_mem_write_reg_q == id_ex_rt)) begin
            forward_b = 2'b10;
        end else if (mem_wb_reg_write_q && (mem_wb_write_reg_q != '0) &&
                     (mem_wb_write_reg_q == id_ex_rt)) begin
            forward_b = 2'b01;
        end
    end

    always_comb begin
        stall_d = 1'b0;
        if (id_ex_mem_read && (id_ex_write_reg != '0) &&
            ((id_ex_write_reg == if_id_rs) || (id_ex_write_reg == if_id_rt))) begin
            stall_d = 1'b1;
        end
    end

    assign ForwardA          = forward_a;
    assign ForwardB          = forward_b;
    assign stall             = stall_d;
    assign ex_mem_alu_result = ex_mem_alu_result_q;
    assign ex_mem_write_data = ex_mem_write_data_q;
    assign ex_mem_write_reg  = ex_mem_write_reg_q;
    assign ex_mem_reg_write  = ex_mem_reg_write_q;
    assign ex_mem_mem_read   = ex_mem_mem_read_q;
    assign ex_mem_mem_write  = ex_mem_mem_write_q;
    assign mem_wb_write_data = mem_wb_write_data_q;
    assign mem_wb_write_reg  = mem_wb_write_reg_q;
    assign mem_wb_reg_write  = mem_wb_reg_write_q;

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] fwd_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             fwd_event;

    // Both selects active in one cycle still count as a single event.
    assign fwd_event = (forward_a != 2'b00) || (forward_b != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fwd_event && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            end
            if (stall_d && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fwd_cnt   = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_pipe_ctrl.sv
// Directed scoreboard bench for fwd_pipe_ctrl; counter expectations follow FWD_STATS_EN.
module tb_fwd_pipe_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] id_ex_rs;
    logic [REG_AW-1:0] id_ex_rt;
    logic [REG_AW-1:0] id_ex_write_reg;
    logic              id_ex_reg_write;
    logic              id_ex_mem_read;
    logic              id_ex_mem_write;
    logic [REG_AW-1:0] if_id_rs;
    logic [REG_AW-1:0] if_id_rt;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              flush;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              stall;
    logic [DATA_W-1:0] ex_mem_alu_result;
    logic [DATA_W-1:0] ex_mem_write_data;
    logic [REG_AW-1:0] ex_mem_write_reg;
    logic              ex_mem_reg_write;
    logic              ex_mem_mem_read;
    logic              ex_mem_mem_write;
    logic [DATA_W-1:0] mem_wb_write_data;
    logic [REG_AW-1:0] mem_wb_write_reg;
    logic              mem_wb_reg_write;
    logic [CNT_W-1:0]  fwd_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    int unsigned n_err;
    int unsigned n_chk;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    fwd_pipe_ctrl #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_ex_rs         (id_ex_rs),
        .id_ex_rt         (id_ex_rt),
        .id_ex_write_reg  (id_ex_write_reg),
        .id_ex_reg_write  (id_ex_reg_write),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_mem_write  (id_ex_mem_write),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .alu_result       (alu_result),
        .write_data       (write_data),
        .mem_read_data    (mem_read_data),
        .flush            (flush),
        .ForwardA         (ForwardA),
        .ForwardB         (ForwardB),
        .stall            (stall),
        .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_write_data(ex_mem_write_data),
        .ex_mem_write_reg (ex_mem_write_reg),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_mem_read  (ex_mem_mem_read),
        .ex_mem_mem_write (ex_mem_mem_write),
        .mem_wb_write_data(mem_wb_write_data),
        .mem_wb_write_reg (mem_wb_write_reg),
        .mem_wb_reg_write (mem_wb_reg_write),
        .fwd_cnt          (fwd_cnt),
        .stall_cnt        (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed=%0h required=<entry>", obs);
            return;
        end
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_ex_rs        = '0;
        id_ex_rt        = '0;
        id_ex_write_reg = '0;
        id_ex_reg_write = 1'b0;
        id_ex_mem_read  = 1'b0;
        id_ex_mem_write = 1'b0;
        if_id_rs        = '0;
        if_id_rt        = '0;
        alu_result      = '0;
        write_data      = '0;
        mem_read_data   = '0;
        flush           = 1'b0;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst   = 1'b1;
        clear_in();
        step();
        step();

        // Reset state
        push("rst_fwd_a", 32'd0);      pop_chk(32'(ForwardA));
        push("rst_stall", 32'd0);      pop_chk(32'(stall));
        push("rst_mem_wb_data", 32'd0); pop_chk(mem_wb_write_data);
        push("rst_fwd_cnt", 32'd0);    pop_chk(32'(fwd_cnt));
        rst = 1'b0;

        // EX/MEM forward to rs
        id_ex_write_reg = 5'd3; id_ex_reg_write = 1'b1; alu_result = 32'h0000_0010;
        step();
        clear_in();
        id_ex_rs = 5'd3; id_ex_rt = 5'd4;
        push("exm_fwd_a", 32'd2);
        push("exm_fwd_b", 32'd0);
        push("exm_alu", 32'h10);
        push("exm_reg_write", 32'd1);
        #1;
        pop_chk(32'(ForwardA));
        pop_chk(32'(ForwardB));
        pop_chk(ex_mem_alu_result);
        pop_chk(32'(ex_mem_reg_write));

        // Two writers of r7: EX/MEM wins, then MEM/WB forwards the newer value
        clear_in();
        id_ex_write_reg = 5'd7; id_ex_reg_write = 1'b1; alu_result = 32'hA;
        step();
        alu_result = 32'hB;
        step();
        clear_in();
        id_ex_rt = 5'd7;
        push("prio_fwd_b", 32'd2);
        #1;
        pop_chk(32'(ForwardB));
        step();
        push("memwb_fwd_b", 32'd1);
        push("memwb_data", 32'hB);
        pop_chk(32'(ForwardB));
        pop_chk(mem_wb_write_data);

        // Load-use stall and load writeback path
        clear_in();
        id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_write_reg = 5'd8;
        if_id_rt = 5'd8; alu_result = 32'h1234;
        push("load_stall", 32'd1);
        #1;
        pop_chk(32'(stall));
        if_id_rt = 5'd9;
        push("load_no_match", 32'd0);
        #1;
        pop_chk(32'(stall));
        step();
        clear_in();
        mem_read_data = 32'hDEAD_BEEF;
        push("load_exm_read", 32'd1);
        pop_chk(32'(ex_mem_mem_read));
        step();
        id_ex_rs = 5'd8;
        push("load_wb_data", 32'hDEAD_BEEF);
        push("load_wb_reg", 32'd8);
        push("load_fwd_a", 32'd1);
        #1;
        pop_chk(mem_wb_write_data);
        pop_chk(32'(mem_wb_write_reg));
        pop_chk(32'(ForwardA));

        // Register 0 is never forwarded nor stalled on
        clear_in();
        id_ex_write_reg = 5'd0; id_ex_reg_write = 1'b1; alu_result = 32'h55;
        step();
        clear_in();
        push("r0_fwd_a", 32'd0);
        #1;
        pop_chk(32'(ForwardA));
        id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_write_reg = 5'd0;
        push("r0_stall", 32'd0);
        #1;
        pop_chk(32'(stall));

        // Flushed writer of r9 must not commit or forward
        clear_in();
        id_ex_write_reg = 5'd9; id_ex_reg_write = 1'b1; flush = 1'b1;
        step();
        clear_in();
        id_ex_rs = 5'd9;
        push("flush_exm_rw", 32'd0);
        push("flush_fwd_a", 32'd0);
        #1;
        pop_chk(32'(ex_mem_reg_write));
        pop_chk(32'(ForwardA));
        step();
        push("flush_wb_fwd_a", 32'd0);
        pop_chk(32'(ForwardA));

        // Flush together with load-use: stall reported, load dropped
        clear_in();
        id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_write_reg = 5'd10;
        if_id_rs = 5'd10; flush = 1'b1;
        push("flush_stall", 32'd1);
        #1;
        pop_chk(32'(stall));
        step();
        clear_in();
        push("flush_load_drop", 32'd0);
        pop_chk(32'(ex_mem_mem_read));

        // Asynchronous reset mid-stream
        id_ex_write_reg = 5'd5; id_ex_reg_write = 1'b1;
        step();
        clear_in();
        id_ex_rs = 5'd5;
        push("pre_rst_fwd_a", 32'd2);
        #1;
        pop_chk(32'(ForwardA));
        rst = 1'b1;
        push("arst_exm_rw", 32'd0);
        push("arst_exm_reg", 32'd0);
        push("arst_fwd_a", 32'd0);
        push("arst_wb_rw", 32'd0);
        #1;
        pop_chk(32'(ex_mem_reg_write));
        pop_chk(32'(ex_mem_write_reg));
        pop_chk(32'(ForwardA));
        pop_chk(32'(mem_wb_reg_write));
        clear_in();
        step();
        rst = 1'b0;

        // Statistics: three forwarding edges (one with both selects) and two stall edges
        id_ex_write_reg = 5'd3; id_ex_reg_write = 1'b1;
        step();
        clear_in();
        id_ex_rs = 5'd3; id_ex_rt = 5'd3;
        step();
        id_ex_rt = 5'd0;
        step();
        clear_in();
        id_ex_write_reg = 5'd4; id_ex_reg_write = 1'b1;
        step();
        clear_in();
        id_ex_rt = 5'd4;
        step();
        clear_in();
        id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_write_reg = 5'd6; if_id_rs = 5'd6;
        step();
        step();
        clear_in();
`ifdef FWD_STATS_EN
        push("stat_fwd_cnt", 32'd3);
        push("stat_stall_cnt", 32'd2);
`else
        push("stat_fwd_cnt", 32'd0);
        push("stat_stall_cnt", 32'd0);
`endif
        pop_chk(32'(fwd_cnt));
        pop_chk(32'(stall_cnt));

        n_chk++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
